i2c_shift_register_param: RTL and testbench



---
 rtl/i2c_shift_register_param.sv | 80 ++++++++
 tb/tb_i2c_shift_register_param.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_shift_register_param.sv
// i2c_shift_register_param: WIDTH-bit I2C serial/parallel shift register with ShiftClock edge detect and word tracking.
// Optional macro I2C_SHIFT_SYNC_EN adds two-flop synchronizers on ShiftClock and ShiftIn.
module i2c_shift_register_param #(
    parameter int WIDTH = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW = $clog2(WIDTH)
) (
    input  logic             CLOCK,
    input  logic             Reset,
    input  logic             WriteLoad,
    input  logic [WIDTH-1:0] SentData,
    input  logic             ShiftIn,
    input  logic             ShiftorHold,
    input  logic             ShiftClock,
    output logic [WIDTH-1:0] ReceivedData,
    output logic             ShiftOut,
    output logic [CW-1:0]    BitCount,
    output logic             WordDone
);
    logic [WIDTH-1:0] shiftReg;
    logic [WIDTH-1:0] shifted;
    logic             sclkPrev;
    logic             sclkEff;
    logic             sinEff;
    logic             rise;
    logic             lastBit;

`ifdef I2C_SHIFT_SYNC_EN
    logic [1:0] sclkSync;
    logic [1:0] sinSync;

    // Both inputs go through equal-depth synchronizers so the sampled data bit lines up with the detected edge.
    always_ff @(posedge CLOCK or posedge Reset) begin
        if (Reset) begin
            sclkSync <= 2'b11;
            sinSync  <= 2'b00;
        end else begin
            sclkSync <= {sclkSync[0], ShiftClock};
            sinSync  <= {sinSync[0], ShiftIn};
        end
    end

    assign sclkEff = sclkSync[1];
    assign sinEff  = sinSync[1];
`else
    assign sclkEff = ShiftClock;
    assign sinEff  = ShiftIn;
`endif

    // Rising-edge detect on the slow clock, last-bit detect, and the shifted word in the chosen bit order.
    always_comb begin
        rise    = sclkEff & ~sclkPrev;
        lastBit = BitCount == CW'(WIDTH - 1);
        shifted = MSB_FIRST ? {shiftReg[WIDTH-2:0], sinEff} : {sinEff, shiftReg[WIDTH-1:1]};
    end

    // Load beats shift beats hold; sclkPrev resets high so a ShiftClock already high at release is not an edge.
    always_ff @(posedge CLOCK or posedge Reset) begin
        if (Reset) begin
            shiftReg <= '0;
            BitCount <= '0;
            WordDone <= 1'b0;
            sclkPrev <= 1'b1;
        end else begin
            sclkPrev <= sclkEff;
            WordDone <= 1'b0;
            if (WriteLoad) begin
                shiftReg <= SentData;
                BitCount <= '0;
            end else if (rise && ShiftorHold) begin
                shiftReg <= shifted;
                BitCount <= lastBit ? '0 : BitCount + CW'(1);
                WordDone <= lastBit;
            end
        end
    end

    assign ReceivedData = shiftReg;
    assign ShiftOut     = MSB_FIRST ? shiftReg[WIDTH-1] : shiftReg[0];
endmodule

// File: tb/tb_i2c_shift_register_param.sv
// tb_i2c_shift_register_param: random and directed checks of MSB-first and LSB-first instances against a word-level model.
module tb_i2c_shift_register_param;
    localparam int W = 8;
`ifdef I2C_SHIFT_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif

    logic CLOCK = 1'b0;
    logic Reset, WriteLoad, ShiftorHold, ShiftClock, si0, si1;
    logic [7:0] SentData;
    logic [7:0] rd0, rd1;
    logic so0, so1, wd0, wd1;
    logic [2:0] bc0, bc1;

    i2c_shift_register_param #(.WIDTH(W), .MSB_FIRST(1'b1)) u0 (
        .CLOCK(CLOCK), .Reset(Reset), .WriteLoad(WriteLoad), .SentData(SentData), .ShiftIn(si0),
        .ShiftorHold(ShiftorHold), .ShiftClock(ShiftClock), .ReceivedData(rd0), .ShiftOut(so0),
        .BitCount(bc0), .WordDone(wd0));
    i2c_shift_register_param #(.WIDTH(W), .MSB_FIRST(1'b0)) u1 (
        .CLOCK(CLOCK), .Reset(Reset), .WriteLoad(WriteLoad), .SentData(SentData), .ShiftIn(si1),
        .ShiftorHold(ShiftorHold), .ShiftClock(ShiftClock), .ReceivedData(rd1), .ShiftOut(so1),
        .BitCount(bc1), .WordDone(wd1));

    always #5 CLOCK = ~CLOCK;

    int pass = 0;
    int total = 0;
    int doneCnt = 0;

    task automatic chk(string name, int act, int exp);
        total++;
        if (act == exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Word-level model: input history per posedge, words as integers, shift count since last load.
    bit scH[0:3];
    bit inH0[0:3];
    bit inH1[0:3];
    int word0, word1, shifts;
    bit done, mRise;

    task automatic modelReset();
        for (int k = 0; k < 4; k++) begin
            scH[k] = 1'b1;
            inH0[k] = 1'b0;
            inH1[k] = 1'b0;
        end
        word0 = 0;
        word1 = 0;
        shifts = 0;
        done = 1'b0;
    endtask

    always @(posedge Reset) modelReset();

    always @(posedge CLOCK) begin
        if (!Reset) begin
            for (int k = 3; k > 0; k--) begin
                scH[k] = scH[k-1];
                inH0[k] = inH0[k-1];
                inH1[k] = inH1[k-1];
            end
            scH[0] = ShiftClock;
            inH0[0] = si0;
            inH1[0] = si1;
            mRise = scH[D] && !scH[D+1];
            done = 1'b0;
            if (WriteLoad) begin
                word0 = SentData;
                word1 = SentData;
                shifts = 0;
            end else if (mRise && ShiftorHold) begin
                word0 = ((word0 << 1) | inH0[D]) & 8'hFF;
                word1 = (word1 >> 1) | (inH1[D] << 7);
                shifts++;
                done = (shifts % W) == 0;
            end
        end
        #1;
        chk("rd_msb", rd0, word0);
        chk("rd_lsb", rd1, word1);
        chk("so_msb", so0, (word0 >> 7) & 1);
        chk("so_lsb", so1, word1 & 1);
        chk("bc_msb", bc0, shifts % W);
        chk("bc_lsb", bc1, shifts % W);
        chk("wd_msb", wd0, done);
        chk("wd_lsb", wd1, done);
        if (wd0) doneCnt++;
    end

    task automatic cyc(int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic load(logic [7:0] v);
        SentData = v;
        WriteLoad = 1'b1;
        cyc(1);
        WriteLoad = 1'b0;
    endtask

    task automatic edgeBit(bit b0, bit b1);
        si0 = b0;
        si1 = b1;
        ShiftClock = 1'b1;
        cyc(2);
        ShiftClock = 1'b0;
        cyc(2);
    endtask

    logic [7:0] ab = 8'hAB;
    logic [7:0] dd = 8'h35;

    initial begin
        Reset = 1'b0; WriteLoad = 1'b0; ShiftorHold = 1'b0; ShiftClock = 1'b0;
        si0 = 1'b0; si1 = 1'b0; SentData = 8'h00;
        #1 Reset = 1'b1;
        cyc(2);
        chk("reset_rd", rd0, 0);
        chk("reset_so", so0, 0);
        chk("reset_bc", bc0, 0);
        chk("reset_wd", wd0, 0);
        Reset = 1'b0;
        cyc(2);
        // Full word in both bit orders
        ShiftorHold = 1'b1;
        load(ab);
        doneCnt = 0;
        for (int i = 0; i < 8; i++) begin
            chk("s1_so_msb", so0, ab[7-i]);
            chk("s1_so_lsb", so1, ab[i]);
            edgeBit(dd[7-i], dd[i]);
            chk("s1_bc", bc0, (i + 1) % 8);
        end
        chk("s1_rd_msb", rd0, 8'h35);
        chk("s1_rd_lsb", rd1, 8'h35);
        chk("s1_donecnt", doneCnt, 1);
        // Held-high clock gives one shift; hold consumes edges
        load(8'h00);
        si0 = 1'b1; si1 = 1'b1;
        ShiftClock = 1'b1;
        cyc(5);
        ShiftClock = 1'b0;
        cyc(3);
        chk("s3_bc", bc0, 1);
        ShiftorHold = 1'b0;
        repeat (3) begin
            ShiftClock = 1'b1; cyc(2);
            ShiftClock = 1'b0; cyc(2);
        end
        ShiftorHold = 1'b1;
        cyc(4);
        chk("s3_hold_bc", bc0, 1);
        chk("s3_hold_rd_msb", rd0, 8'h01);
        chk("s3_hold_rd_lsb", rd1, 8'h80);
        // Load wins over a simultaneous edge
        SentData = 8'h5A;
        WriteLoad = 1'b1;
        ShiftClock = 1'b1;
        cyc(3);
        WriteLoad = 1'b0;
        cyc(3);
        chk("s4_rd", rd0, 8'h5A);
        chk("s4_rd_lsb", rd1, 8'h5A);
        chk("s4_bc", bc0, 0);
        ShiftClock = 1'b0;
        cyc(3);
        // Reset mid-word, clock high across release
        load(8'h00);
        repeat (3) edgeBit(1'b1, 1'b1);
        chk("s5_pre_bc", bc0, 3);
        chk("s5_pre_rd", rd0, 8'h07);
        Reset = 1'b1;
        ShiftClock = 1'b1;
        #1;
        chk("s5_async_rd", rd0, 0);
        chk("s5_async_rd_lsb", rd1, 0);
        chk("s5_async_bc", bc0, 0);
        chk("s5_async_so", so1, 0);
        cyc(2);
        Reset = 1'b0;
        cyc(5);
        chk("s5_nospur_bc", bc0, 0);
        chk("s5_nospur_rd", rd0, 0);
        ShiftClock = 1'b0;
        cyc(3);
        si0 = 1'b1;
        ShiftClock = 1'b1;
        cyc(4);
        chk("s5_after_bc", bc0, 1);
        chk("s5_after_rd", rd0, 8'h01);
        // Random traffic against the model
        repeat (3000) begin
            Reset = ($urandom % 400) == 0;
            WriteLoad = ($urandom % 16) == 0;
            SentData = 8'($urandom);
            ShiftorHold = ($urandom % 4) != 0;
            if (($urandom % 3) == 0) ShiftClock = ~ShiftClock;
            si0 = 1'($urandom);
            si1 = 1'($urandom);
            cyc(1);
        end
        Reset = 1'b0;
        WriteLoad = 1'b0;
        cyc(2);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
